// File: rtl/wash_pkg.sv
// Shared types and helpers for the wash cycle sequencer.
// Holds the FSM state enum, the phase codes seen on the phase output, the default
// cloth limit, and helpers that pick the next non-empty phase and its duration.
package wash_pkg;

  typedef enum logic [2:0] {StIdle, StWash, StRinse, StSpin, StDone} state_e;

  typedef enum logic [1:0] {
    PhaseIdle  = 2'd0,
    PhaseWash  = 2'd1,
    PhaseRinse = 2'd2,
    PhaseSpin  = 2'd3
  } phase_e;

  localparam logic [4:0] MaxClothDefault = 5'd20;

  // First phase after cur whose time is nonzero; DONE when none remains.
  function automatic state_e next_phase(input state_e cur, input logic [4:0] w,
                                        input logic [4:0] r, input logic [4:0] s);
    state_e nxt;
    nxt = StDone;
    if (cur == StIdle && w != 5'd0) begin
      nxt = StWash;
    end else if ((cur == StIdle || cur == StWash) && r != 5'd0) begin
      nxt = StRinse;
    end else if ((cur == StIdle || cur == StWash || cur == StRinse) && s != 5'd0) begin
      nxt = StSpin;
    end
    return nxt;
  endfunction

  function automatic logic [4:0] phase_time(input state_e st, input logic [4:0] w,
                                            input logic [4:0] r, input logic [4:0] s);
    logic [4:0] t;
    case (st)
      StWash:  t = w;
      StRinse: t = r;
      StSpin:  t = s;
      default: t = 5'd0;
    endcase
    return t;
  endfunction

  function automatic phase_e phase_code(input state_e st);
    phase_e p;
    case (st)
      StWash:  p = PhaseWash;
      StRinse: p = PhaseRinse;
      StSpin:  p = PhaseSpin;
      default: p = PhaseIdle;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/unit_timer.sv
// Prescaler plus time-unit down-counter for one wash phase.
// Ports: clk_i/rst_i (sync, active-high); load_i/load_val_i restart the count with
// prescaler cleared; en_i advances one cycle; remaining_o is the registered unit count;
// tc_o pulses on the enabled cycle that takes remaining from 1 to 0.
module unit_timer #(
  parameter int unsigned TICKS_PER_UNIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [4:0] load_val_i,
  input  logic       en_i,
  output logic [4:0] remaining_o,
  output logic       tc_o
);

  localparam logic [7:0] PreMax = 8'(TICKS_PER_UNIT - 1);

  logic [7:0] pre_q;
  logic [4:0] rem_q;
  logic       wrap;

  assign wrap        = (pre_q == PreMax);
  // Independent of load_i so the FSM can use it to decide whether to load.
  assign tc_o        = en_i && wrap && (rem_q == 5'd1);
  assign remaining_o = rem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= 8'd0;
      rem_q <= 5'd0;
    end else if (load_i) begin
      pre_q <= 8'd0;
      rem_q <= load_val_i;
    end else if (en_i) begin
      if (wrap) begin
        pre_q <= 8'd0;
        rem_q <= rem_q - 5'd1;
      end else begin
        pre_q <= pre_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle sequencer: IDLE -> WASH -> RINSE -> SPIN -> DONE, skipping
// phases with zero time. Inputs: start_i/abort_i pulses, pause_i level, phase times,
// cloth load. Outputs (all registered): busy_o, phase_o, remaining_o, done_o pulse,
// sticky error_o for rejected starts, and the three actuator enables.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 4,
  parameter logic [4:0]  MAX_CLOTH      = MaxClothDefault
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       abort_i,
  input  logic [4:0] wash_time_i,
  input  logic [4:0] rinse_time_i,
  input  logic [4:0] spin_time_i,
  input  logic [4:0] cloth_i,
  output logic       busy_o,
  output logic [1:0] phase_o,
  output logic [4:0] remaining_o,
  output logic       done_o,
  output logic       error_o,
  output logic       valve_on_o,
  output logic       drum_on_o,
  output logic       spin_motor_o
);

  state_e     state_q, state_d;
  logic [4:0] wash_time_q, wash_time_d;
  logic [4:0] rinse_time_q, rinse_time_d;
  logic [4:0] spin_time_q, spin_time_d;
  logic       error_q, error_d;
  logic       busy_q, busy_d;
  logic [1:0] phase_q, phase_d;
  logic       done_q, done_d;
  logic       valve_q, valve_d;
  logic       drum_q, drum_d;
  logic       spin_motor_q, spin_motor_d;

  logic       tmr_load, tmr_en, tmr_tc;
  logic [4:0] tmr_load_val;
  logic       active_q, freeze;

  assign active_q = (state_q == StWash) || (state_q == StRinse) || (state_q == StSpin);
  assign freeze   = pause_i && active_q;

  unit_timer #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .remaining_o(remaining_o),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    wash_time_d  = wash_time_q;
    rinse_time_d = rinse_time_q;
    spin_time_d  = spin_time_q;
    error_d      = error_q;
    tmr_load     = 1'b0;
    tmr_load_val = 5'd0;
    tmr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Abort alongside start cancels the request and leaves error untouched.
        if (start_i && !abort_i) begin
          if (cloth_i == 5'd0 || cloth_i > MAX_CLOTH) begin
            error_d = 1'b1;
          end else begin
            wash_time_d  = wash_time_i;
            rinse_time_d = rinse_time_i;
            spin_time_d  = spin_time_i;
            error_d      = 1'b0;
            state_d      = next_phase(StIdle, wash_time_i, rinse_time_i, spin_time_i);
            tmr_load     = 1'b1;
            tmr_load_val = phase_time(state_d, wash_time_i, rinse_time_i, spin_time_i);
          end
        end
      end
      StWash, StRinse, StSpin: begin
        if (abort_i) begin
          state_d  = StIdle;
          tmr_load = 1'b1;
        end else if (!pause_i) begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d      = next_phase(state_q, wash_time_q, rinse_time_q, spin_time_q);
            tmr_load     = 1'b1;
            tmr_load_val = phase_time(state_d, wash_time_q, rinse_time_q, spin_time_q);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are computed from the next state so they can be registered.
    busy_d       = (state_d == StWash) || (state_d == StRinse) || (state_d == StSpin);
    phase_d      = phase_code(state_d);
    done_d       = (state_d == StDone);
    valve_d      = ((state_d == StWash) || (state_d == StRinse)) && !freeze;
    drum_d       = valve_d;
    spin_motor_d = (state_d == StSpin) && !freeze;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      wash_time_q  <= 5'd0;
      rinse_time_q <= 5'd0;
      spin_time_q  <= 5'd0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      phase_q      <= 2'd0;
      done_q       <= 1'b0;
      valve_q      <= 1'b0;
      drum_q       <= 1'b0;
      spin_motor_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wash_time_q  <= wash_time_d;
      rinse_time_q <= rinse_time_d;
      spin_time_q  <= spin_time_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      phase_q      <= phase_d;
      done_q       <= done_d;
      valve_q      <= valve_d;
      drum_q       <= drum_d;
      spin_motor_q <= spin_motor_d;
    end
  end

  assign busy_o       = busy_q;
  assign phase_o      = phase_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign valve_on_o   = valve_q;
  assign drum_on_o    = drum_q;
  assign spin_motor_o = spin_motor_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Scoreboard bench for wash_cycle_sequencer with TICKS_PER_UNIT=2, MAX_CLOTH=20.
// Stimulus pushes the hand-derived expected output vector for every clock; a monitor
// pops one entry per negative edge and compares it with the DUT outputs.
module tb_wash_cycle_sequencer;

  typedef struct packed {
    logic       busy;
    logic [1:0] phase;
    logic [4:0] rem;
    logic       done;
    logic       err;
    logic       valve;
    logic       drum;
    logic       spinm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] wash_t = 5'd0, rinse_t = 5'd0, spin_t = 5'd0, cloth = 5'd0;
  logic       busy, done, error, valve, drum, spinm;
  logic [1:0] phase;
  logic [4:0] remaining;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  wash_cycle_sequencer #(
    .TICKS_PER_UNIT(2),
    .MAX_CLOTH     (5'd20)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .pause_i     (pause),
    .abort_i     (abort),
    .wash_time_i (wash_t),
    .rinse_time_i(rinse_t),
    .spin_time_i (spin_t),
    .cloth_i     (cloth),
    .busy_o      (busy),
    .phase_o     (phase),
    .remaining_o (remaining),
    .done_o      (done),
    .error_o     (error),
    .valve_on_o  (valve),
    .drum_on_o   (drum),
    .spin_motor_o(spinm)
  );

  function automatic exp_t e_idle(input logic err);
    return '{busy: 1'b0, phase: 2'd0, rem: 5'd0, done: 1'b0, err: err,
             valve: 1'b0, drum: 1'b0, spinm: 1'b0};
  endfunction

  function automatic exp_t e_done();
    return '{busy: 1'b0, phase: 2'd0, rem: 5'd0, done: 1'b1, err: 1'b0,
             valve: 1'b0, drum: 1'b0, spinm: 1'b0};
  endfunction

  function automatic exp_t e_ph(input logic [1:0] ph, input logic [4:0] rem,
                                input logic paused);
    logic wet;
    wet = (ph == 2'd1 || ph == 2'd2) && !paused;
    return '{busy: 1'b1, phase: ph, rem: rem, done: 1'b0, err: 1'b0,
             valve: wet, drum: wet, spinm: (ph == 2'd3) && !paused};
  endfunction

  // One clock: expectation applies to outputs seen after this edge.
  task automatic tick(input exp_t e, input string nm);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Unpaused phase of t units: remaining drops every 2 cycles.
  task automatic run_phase(input logic [1:0] ph, input int t, input string nm);
    for (int k = 0; k < 2 * t; k++) tick(e_ph(ph, 5'(t - k / 2), 1'b0), nm);
  endtask

  task automatic req(input logic [4:0] w, input logic [4:0] r, input logic [4:0] s,
                     input logic [4:0] c);
    wash_t  = w;
    rinse_t = r;
    spin_t  = s;
    cloth   = c;
    start   = 1'b1;
  endtask

  initial begin : monitor
    exp_t  e, act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = '{busy: busy, phase: phase, rem: remaining, done: done, err: error,
                valve: valve, drum: drum, spinm: spinm};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s t=%0t got busy=%b ph=%0d rem=%0d done=%b err=%b v=%b d=%b s=%b exp busy=%b ph=%0d rem=%0d done=%b err=%b v=%b d=%b s=%b",
                   nm, $time, act.busy, act.phase, act.rem, act.done, act.err, act.valve,
                   act.drum, act.spinm, e.busy, e.phase, e.rem, e.done, e.err, e.valve,
                   e.drum, e.spinm);
        end
      end
    end
  end

  initial begin : stimulus
    tick(e_idle(1'b0), "reset0");
    tick(e_idle(1'b0), "reset1");
    rst = 1'b0;
    tick(e_idle(1'b0), "idle_after_reset");

    // Full cycle 3/2/1.
    req(5'd3, 5'd2, 5'd1, 5'd10);
    run_phase(2'd1, 3, "full_wash");
    run_phase(2'd2, 2, "full_rinse");
    run_phase(2'd3, 1, "full_spin");
    tick(e_done(), "full_done");
    tick(e_idle(1'b0), "full_idle");

    // Rejected starts, then a valid start that skips wash and spin.
    req(5'd3, 5'd3, 5'd3, 5'd0);
    tick(e_idle(1'b1), "cloth0_err");
    tick(e_idle(1'b1), "err_sticky");
    req(5'd3, 5'd3, 5'd3, 5'd21);
    tick(e_idle(1'b1), "cloth21_err");
    req(5'd0, 5'd2, 5'd0, 5'd5);
    run_phase(2'd2, 2, "skip_rinse");
    tick(e_done(), "skip_done");
    tick(e_idle(1'b0), "skip_idle");

    // Cloth exactly at the limit is accepted.
    req(5'd1, 5'd0, 5'd0, 5'd20);
    run_phase(2'd1, 1, "cloth20_wash");
    tick(e_done(), "cloth20_done");
    tick(e_idle(1'b0), "cloth20_idle");

    // All times zero: straight to DONE.
    req(5'd0, 5'd0, 5'd0, 5'd1);
    tick(e_done(), "zero_done");
    tick(e_idle(1'b0), "zero_idle");

    // Pause for 5 cycles with remaining=2 in WASH.
    req(5'd3, 5'd0, 5'd0, 5'd10);
    tick(e_ph(2'd1, 5'd3, 1'b0), "pause_pre");
    tick(e_ph(2'd1, 5'd3, 1'b0), "pause_pre");
    tick(e_ph(2'd1, 5'd2, 1'b0), "pause_pre");
    pause = 1'b1;
    for (int i = 0; i < 5; i++) tick(e_ph(2'd1, 5'd2, 1'b1), "pause_hold");
    pause = 1'b0;
    tick(e_ph(2'd1, 5'd2, 1'b0), "pause_post");
    tick(e_ph(2'd1, 5'd1, 1'b0), "pause_post");
    tick(e_ph(2'd1, 5'd1, 1'b0), "pause_post");
    tick(e_done(), "pause_done");
    tick(e_idle(1'b0), "pause_idle");

    // Abort in SPIN while paused.
    req(5'd1, 5'd0, 5'd2, 5'd3);
    run_phase(2'd1, 1, "abort_wash");
    tick(e_ph(2'd3, 5'd2, 1'b0), "abort_spin");
    pause = 1'b1;
    tick(e_ph(2'd3, 5'd2, 1'b1), "abort_spin_paused");
    abort = 1'b1;
    tick(e_idle(1'b0), "abort_idle");
    pause = 1'b0;
    tick(e_idle(1'b0), "abort_no_done");
    tick(e_idle(1'b0), "abort_no_done");

    // Second start mid-RINSE ignored, then reset mid-RINSE.
    req(5'd1, 5'd3, 5'd1, 5'd4);
    run_phase(2'd1, 1, "rst_wash");
    tick(e_ph(2'd2, 5'd3, 1'b0), "rst_rinse");
    tick(e_ph(2'd2, 5'd3, 1'b0), "rst_rinse");
    tick(e_ph(2'd2, 5'd2, 1'b0), "rst_rinse");
    req(5'd5, 5'd5, 5'd5, 5'd5);
    tick(e_ph(2'd2, 5'd2, 1'b0), "restart_ignored");
    rst = 1'b1;
    tick(e_idle(1'b0), "rst_mid_rinse");
    rst = 1'b0;
    tick(e_idle(1'b0), "rst_release");

    // Abort beats start in IDLE and leaves error alone; reset clears error.
    req(5'd1, 5'd1, 5'd1, 5'd25);
    tick(e_idle(1'b1), "cloth25_err");
    req(5'd1, 5'd1, 5'd1, 5'd5);
    abort = 1'b1;
    tick(e_idle(1'b1), "abort_beats_start");
    rst = 1'b1;
    tick(e_idle(1'b0), "rst_clears_err");
    rst = 1'b0;

    // Spin-only cycle after reset.
    req(5'd0, 5'd0, 5'd1, 5'd1);
    run_phase(2'd3, 1, "spin_only");
    tick(e_done(), "spin_only_done");
    tick(e_idle(1'b0), "spin_only_idle");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
REQ-001 Parameter TICKS_PER_UNIT, default 4: clock cycles per time unit, legal range 1..255.
REQ-002 Parameter MAX_CLOTH, default 5'd20: largest accepted cloth load.
REQ-003 clk  in  1  the single clock; all logic is rising-edge triggered.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to begin a cycle.
REQ-006 pause  in  1  level input; while high, the running cycle is frozen.
REQ-007 abort  in  1  single-cycle request to cancel the running cycle.
REQ-008 wash_time, rinse_time, spin_time  in  5 each  phase durations in time units.
REQ-009 cloth  in  5  cloth load, checked when start is sampled.
REQ-010 busy  out  1  high in WASH, RINSE and SPIN.
REQ-011 phase  out  2  phase code: 0=idle/done, 1=wash, 2=rinse, 3=spin.
REQ-012 remaining  out  5  time units left in the current phase; 0 when idle.
REQ-013 done  out  1  one-cycle pulse when a cycle completes normally.
REQ-014 error  out  1  sticky rejected-start flag.
REQ-015 valve_on, drum_on, spin_motor  out  1 each  actuator enables.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, WASH, RINSE, SPIN and DONE.
REQ-017 Start handling in IDLE with abort low:
- cloth==0 or cloth>MAX_CLOTH: set error=1 and stay in IDLE.
- otherwise: latch all three times, clear error, and enter the first phase with nonzero time on the next edge.
REQ-018 A phase whose latched time is 0 SHALL be skipped; if all three times are 0, an accepted start SHALL go directly to DONE.
REQ-019 On phase entry, the prescaler SHALL be 0 and remaining SHALL equal the latched time.
REQ-020 Counting, on each unpaused edge:
- the prescaler increments;
- at TICKS_PER_UNIT-1 the prescaler wraps to 0 and remaining decrements;
- a decrement from 1 advances to the next nonzero phase, or to DONE if none remains.
REQ-021 Each phase SHALL therefore last exactly time*TICKS_PER_UNIT unpaused cycles.
REQ-022 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
REQ-023 start SHALL be ignored outside IDLE, and inputs SHALL NOT be re-latched mid-cycle.
REQ-024 pause high in WASH, RINSE or SPIN SHALL:
- hold the state, prescaler and remaining;
- force valve_on, drum_on and spin_motor to 0;
- leave busy and phase unchanged.
REQ-025 pause SHALL have no effect in IDLE or DONE.
REQ-026 abort high in WASH, RINSE, SPIN or DONE SHALL force IDLE on the next edge, regardless of pause; no done pulse is produced.
REQ-027 abort and start sampled together in IDLE: abort wins, start is ignored, and error is unchanged.
REQ-028 Actuator enables:
- valve_on=1 in WASH and RINSE;
- drum_on=1 in WASH and RINSE;
- spin_motor=1 in SPIN;
- all are 0 elsewhere and whenever pause is high.
REQ-029 All outputs SHALL be registered; none SHALL be combinationally dependent on any input.

Reset
REQ-030 rst SHALL take priority over start, abort and pause.
REQ-031 rst SHALL force IDLE, prescaler=0, all latched times=0, busy=0, phase=0, remaining=0, done=0, error=0, and all actuators=0 on the next edge, including mid-cycle.

Structure
REQ-032 Package wash_pkg SHALL hold the state enum, the phase codes and the MAX_CLOTH default.
REQ-033 The prescaler and down-counter SHALL be one sub-module, unit_timer:
- inputs: load, load value, enable;
- output: terminal-count pulse.
REQ-034 The FSM SHALL stay in wash_cycle_sequencer.

Verification (TICKS_PER_UNIT=2)
REQ-035 wash=3, rinse=2, spin=1, cloth=10, start pulse: phase=1 for 6 cycles, then 2 for 4, then 3 for 2, then done=1 for 1 cycle, then busy=0.
REQ-036 cloth=0, then cloth=21: error=1 and busy stays 0; a later valid start clears error.
REQ-037 wash=0, rinse=2, spin=0, cloth=5: phase goes 0->2 directly for 4 cycles, then DONE.
REQ-038 Pause held 5 cycles during WASH with remaining=2: remaining holds at 2, actuators are 0, and total WASH duration grows by exactly 5 cycles.
REQ-039 Abort during SPIN while paused: IDLE next cycle, done never pulses, remaining=0.
REQ-040 rst asserted mid-RINSE: next cycle all outputs are at reset values; a second start during a busy cycle does not change remaining.
